// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-ported, hold-until-ready memory
// between the instruction-fetch port and the data port of the core.
// Each requester has a one-entry pending slot. Data wins over fetch.
// Each access returns one registered ready pulse to its owner.
// Optional watchdog: define MEM_ARB_TIMEOUT_EN to abort accesses that wait
// TIMEOUT_CYCLES cycles without mem_ready_i and raise a sticky error.
module unified_mem_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      if_req_i,
   input  logic [ADDR_WIDTH-1:0]     if_addr_i,
   output logic [DATA_WIDTH-1:0]     if_rdata_o,
   output logic                      if_ready_o,
   input  logic                      d_read_i,
   input  logic                      d_write_i,
   input  logic [ADDR_WIDTH-1:0]     d_addr_i,
   input  logic [DATA_WIDTH-1:0]     d_wdata_i,
   input  logic [DATA_WIDTH/8-1:0]   d_wstrb_i,
   output logic [DATA_WIDTH-1:0]     d_rdata_o,
   output logic                      d_ready_o,
   output logic                      mem_req_o,
   output logic                      mem_we_o,
   output logic [ADDR_WIDTH-1:0]     mem_addr_o,
   output logic [DATA_WIDTH-1:0]     mem_wdata_o,
   output logic [DATA_WIDTH/8-1:0]   mem_wstrb_o,
   input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
   input  logic                      mem_ready_i,
   output logic                      busy_o,
   output logic                      timeout_err_o
);

   localparam int SW = DATA_WIDTH / 8;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   // A watchdog shorter than two cycles cannot tell a slow memory from a dead one
   if (TIMEOUT_CYCLES < 2) begin : gBadTimeout
      $error("unified_mem_arbiter: TIMEOUT_CYCLES must be >= 2");
   end

   state_t                state_q, state_d;
   logic                  ownerData_q, ownerData_d;
   logic                  ifPend_q, ifPend_d;
   logic [ADDR_WIDTH-1:0] ifAddr_q, ifAddr_d;
   logic                  dPend_q, dPend_d;
   logic                  dWe_q, dWe_d;
   logic [ADDR_WIDTH-1:0] dAddr_q, dAddr_d;
   logic [DATA_WIDTH-1:0] dWdata_q, dWdata_d;
   logic [SW-1:0]         dWstrb_q, dWstrb_d;
   logic                  memReq_q, memReq_d;
   logic                  memWe_q, memWe_d;
   logic [ADDR_WIDTH-1:0] memAddr_q, memAddr_d;
   logic [DATA_WIDTH-1:0] memWdata_q, memWdata_d;
   logic [SW-1:0]         memWstrb_q, memWstrb_d;
   logic                  ifReady_q, ifReady_d;
   logic [DATA_WIDTH-1:0] ifRdata_q, ifRdata_d;
   logic                  dReady_q, dReady_d;
   logic [DATA_WIDTH-1:0] dRdata_q, dRdata_d;
   logic                  ifAccept, dAccept;
   logic                  selWe;
   logic [ADDR_WIDTH-1:0] selAddr;
   logic [DATA_WIDTH-1:0] selWdata;
   logic [SW-1:0]         selWstrb;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] timer_q, timer_d;
   logic          timeoutErr_q, timeoutErr_d;
`endif

   // Register every piece of arbiter state; reset empties both slots and zeroes outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ownerData_q <= 1'b0;
         ifPend_q    <= 1'b0;
         ifAddr_q    <= '0;
         dPend_q     <= 1'b0;
         dWe_q       <= 1'b0;
         dAddr_q     <= '0;
         dWdata_q    <= '0;
         dWstrb_q    <= '0;
         memReq_q    <= 1'b0;
         memWe_q     <= 1'b0;
         memAddr_q   <= '0;
         memWdata_q  <= '0;
         memWstrb_q  <= '0;
         ifReady_q   <= 1'b0;
         ifRdata_q   <= '0;
         dReady_q    <= 1'b0;
         dRdata_q    <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
         timer_q      <= '0;
         timeoutErr_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         ownerData_q <= ownerData_d;
         ifPend_q    <= ifPend_d;
         ifAddr_q    <= ifAddr_d;
         dPend_q     <= dPend_d;
         dWe_q       <= dWe_d;
         dAddr_q     <= dAddr_d;
         dWdata_q    <= dWdata_d;
         dWstrb_q    <= dWstrb_d;
         memReq_q    <= memReq_d;
         memWe_q     <= memWe_d;
         memAddr_q   <= memAddr_d;
         memWdata_q  <= memWdata_d;
         memWstrb_q  <= memWstrb_d;
         ifReady_q   <= ifReady_d;
         ifRdata_q   <= ifRdata_d;
         dReady_q    <= dReady_d;
         dRdata_q    <= dRdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
         timer_q      <= timer_d;
         timeoutErr_q <= timeoutErr_d;
`endif
      end
   end

   // Slot capture, fixed-priority selection and the IDLE/ACCESS handshake sequencing
   always_comb begin
      state_d     = state_q;
      ownerData_d = ownerData_q;
      ifPend_d    = ifPend_q;
      ifAddr_d    = ifAddr_q;
      dPend_d     = dPend_q;
      dWe_d       = dWe_q;
      dAddr_d     = dAddr_q;
      dWdata_d    = dWdata_q;
      dWstrb_d    = dWstrb_q;
      memReq_d    = memReq_q;
      memWe_d     = memWe_q;
      memAddr_d   = memAddr_q;
      memWdata_d  = memWdata_q;
      memWstrb_d  = memWstrb_q;
      ifReady_d   = 1'b0;
      ifRdata_d   = ifRdata_q;
      dReady_d    = 1'b0;
      dRdata_d    = dRdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
      timer_d      = timer_q;
      timeoutErr_d = timeoutErr_q;
`endif

      // A pulse is dropped while its requester already has an access queued or in flight
      ifAccept = if_req_i & ~ifPend_q & ~((state_q == ACCESS) & ~ownerData_q);
      dAccept  = (d_read_i | d_write_i) & ~dPend_q & ~((state_q == ACCESS) & ownerData_q);

      // A pending data slot takes precedence over this cycle's pulse, which is ignored then
      selWe    = dPend_q ? dWe_q    : d_write_i;
      selAddr  = dPend_q ? dAddr_q  : d_addr_i;
      selWdata = dPend_q ? dWdata_q : d_wdata_i;
      selWstrb = dPend_q ? dWstrb_q : d_wstrb_i;

      case (state_q)
         IDLE: begin
            if (dPend_q | dAccept) begin
               state_d     = ACCESS;
               ownerData_d = 1'b1;
               dPend_d     = 1'b0;
               memReq_d    = 1'b1;
               memWe_d     = selWe;
               memAddr_d   = selAddr;
               memWdata_d  = selWe ? selWdata : '0;
               memWstrb_d  = selWe ? selWstrb : '0;
               if (ifAccept) begin
                  ifPend_d = 1'b1;
                  ifAddr_d = if_addr_i;
               end
            end else if (ifPend_q | ifAccept) begin
               state_d     = ACCESS;
               ownerData_d = 1'b0;
               ifPend_d    = 1'b0;
               memReq_d    = 1'b1;
               memWe_d     = 1'b0;
               memAddr_d   = ifPend_q ? ifAddr_q : if_addr_i;
               memWdata_d  = '0;
               memWstrb_d  = '0;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            timer_d = '0;
`endif
         end
         ACCESS: begin
            if (ifAccept) begin
               ifPend_d = 1'b1;
               ifAddr_d = if_addr_i;
            end
            if (dAccept) begin
               dPend_d  = 1'b1;
               dWe_d    = d_write_i;
               dAddr_d  = d_addr_i;
               dWdata_d = d_wdata_i;
               dWstrb_d = d_wstrb_i;
            end
            if (mem_ready_i) begin
               state_d  = IDLE;
               memReq_d = 1'b0;
               if (ownerData_q) begin
                  dReady_d = 1'b1;
                  dRdata_d = memWe_q ? '0 : mem_rdata_i;
               end else begin
                  ifReady_d = 1'b1;
                  ifRdata_d = mem_rdata_i;
               end
            end
`ifdef MEM_ARB_TIMEOUT_EN
            else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
               state_d      = IDLE;
               memReq_d     = 1'b0;
               timeoutErr_d = 1'b1;
               if (ownerData_q) begin
                  dReady_d = 1'b1;
                  dRdata_d = '0;
               end else begin
                  ifReady_d = 1'b1;
                  ifRdata_d = '0;
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   assign if_rdata_o  = ifRdata_q;
   assign if_ready_o  = ifReady_q;
   assign d_rdata_o   = dRdata_q;
   assign d_ready_o   = dReady_q;
   assign mem_req_o   = memReq_q;
   assign mem_we_o    = memWe_q;
   assign mem_addr_o  = memAddr_q;
   assign mem_wdata_o = memWdata_q;
   assign mem_wstrb_o = memWstrb_q;
   assign busy_o      = (state_q == ACCESS);

`ifdef MEM_ARB_TIMEOUT_EN
   assign timeout_err_o = timeoutErr_q;
`else
   assign timeout_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed scenarios for unified_mem_arbiter with
// hand-computed expectations; inputs change #1 after a rising edge and
// registered outputs are checked at that same point.
module tb_unified_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic [31:0] if_rdata_o;
   logic        if_ready_o;
   logic        d_read_i;
   logic        d_write_i;
   logic [31:0] d_addr_i;
   logic [31:0] d_wdata_i;
   logic [3:0]  d_wstrb_i;
   logic [31:0] d_rdata_o;
   logic        d_ready_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [3:0]  mem_wstrb_o;
   logic [31:0] mem_rdata_i;
   logic        mem_ready_i;
   logic        busy_o;
   logic        timeout_err_o;

   int nCompared   = 0;
   int nMismatched = 0;

   unified_mem_arbiter #(
      .ADDR_WIDTH     (32),
      .DATA_WIDTH     (32),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .if_req_i      (if_req_i),
      .if_addr_i     (if_addr_i),
      .if_rdata_o    (if_rdata_o),
      .if_ready_o    (if_ready_o),
      .d_read_i      (d_read_i),
      .d_write_i     (d_write_i),
      .d_addr_i      (d_addr_i),
      .d_wdata_i     (d_wdata_i),
      .d_wstrb_i     (d_wstrb_i),
      .d_rdata_o     (d_rdata_o),
      .d_ready_o     (d_ready_o),
      .mem_req_o     (mem_req_o),
      .mem_we_o      (mem_we_o),
      .mem_addr_o    (mem_addr_o),
      .mem_wdata_o   (mem_wdata_o),
      .mem_wstrb_o   (mem_wstrb_o),
      .mem_rdata_i   (mem_rdata_i),
      .mem_ready_i   (mem_ready_i),
      .busy_o        (busy_o),
      .timeout_err_o (timeout_err_o)
   );

   // Free-running 10 ns clock
   always #5 clk = ~clk;

   // Advance n rising edges and settle just past the last one
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive every requester and memory-side input in one call
   task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr,
                                input logic dRd, input logic dWr, input logic [31:0] dAddr,
                                input logic [31:0] dWdata, input logic [3:0] dWstrb,
                                input logic memRdy, input logic [31:0] memRdata);
      if_req_i    = ifReq;
      if_addr_i   = ifAddr;
      d_read_i    = dRd;
      d_write_i   = dWr;
      d_addr_i    = dAddr;
      d_wdata_i   = dWdata;
      d_wstrb_i   = dWstrb;
      mem_ready_i = memRdy;
      mem_rdata_i = memRdata;
   endtask

   task automatic idleInputs();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
   endtask

   // One comparison: count it, and count and report it if it differs
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      nCompared++;
      assert (observed === expected)
      else begin
         nMismatched++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      idleInputs();
      tick(2);

      // Reset state
      checkOutput("rst_mem_req", 32'(mem_req_o), 32'h0);
      checkOutput("rst_busy", 32'(busy_o), 32'h0);
      checkOutput("rst_if_ready", 32'(if_ready_o), 32'h0);
      checkOutput("rst_d_ready", 32'(d_ready_o), 32'h0);
      checkOutput("rst_if_rdata", if_rdata_o, 32'h0);
      checkOutput("rst_d_rdata", d_rdata_o, 32'h0);
      checkOutput("rst_mem_addr", mem_addr_o, 32'h0);
      checkOutput("rst_timeout", 32'(timeout_err_o), 32'h0);
      rst_n = 1'b1;
      tick(1);

      // Fetch with memory answering two cycles after mem_req_o rises
      $display("[TB] fetch");
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
      tick(1);
      idleInputs();
      checkOutput("fetch_req", 32'(mem_req_o), 32'h1);
      checkOutput("fetch_addr", mem_addr_o, 32'h100);
      checkOutput("fetch_we", 32'(mem_we_o), 32'h0);
      checkOutput("fetch_wstrb", 32'(mem_wstrb_o), 32'h0);
      checkOutput("fetch_busy", 32'(busy_o), 32'h1);
      tick(2);
      checkOutput("fetch_req_held", 32'(mem_req_o), 32'h1);
      checkOutput("fetch_ready_early", 32'(if_ready_o), 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h00500093);
      tick(1);
      idleInputs();
      checkOutput("fetch_ready", 32'(if_ready_o), 32'h1);
      checkOutput("fetch_rdata", if_rdata_o, 32'h00500093);
      checkOutput("fetch_d_ready", 32'(d_ready_o), 32'h0);
      checkOutput("fetch_req_drop", 32'(mem_req_o), 32'h0);
      checkOutput("fetch_busy_drop", 32'(busy_o), 32'h0);
      tick(1);
      checkOutput("fetch_ready_single", 32'(if_ready_o), 32'h0);
      checkOutput("fetch_rdata_hold", if_rdata_o, 32'h00500093);

      // Store answered in the first ACCESS cycle; load data must read back 0
      $display("[TB] store");
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h2004, 32'hCAFEF00D, 4'b0011, 1'b0, 32'h0);
      tick(1);
      checkOutput("store_we", 32'(mem_we_o), 32'h1);
      checkOutput("store_addr", mem_addr_o, 32'h2004);
      checkOutput("store_wdata", mem_wdata_o, 32'hCAFEF00D);
      checkOutput("store_wstrb", 32'(mem_wstrb_o), 32'h3);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF);
      tick(1);
      idleInputs();
      checkOutput("store_ready", 32'(d_ready_o), 32'h1);
      checkOutput("store_rdata", d_rdata_o, 32'h0);
      checkOutput("store_if_ready", 32'(if_ready_o), 32'h0);
      tick(1);
      checkOutput("store_ready_single", 32'(d_ready_o), 32'h0);

      // Contention: data first, then fetch after one IDLE cycle
      $display("[TB] contention");
      applyStimulus(1'b1, 32'h104, 1'b1, 1'b0, 32'h3000, 32'h0, 4'h0, 1'b0, 32'h0);
      tick(1);
      idleInputs();
      checkOutput("cont_first_addr", mem_addr_o, 32'h3000);
      checkOutput("cont_first_we", 32'(mem_we_o), 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h11112222);
      tick(1);
      idleInputs();
      checkOutput("cont_d_ready", 32'(d_ready_o), 32'h1);
      checkOutput("cont_d_rdata", d_rdata_o, 32'h11112222);
      checkOutput("cont_if_ready_quiet", 32'(if_ready_o), 32'h0);
      checkOutput("cont_gap_req", 32'(mem_req_o), 32'h0);
      tick(1);
      checkOutput("cont_second_req", 32'(mem_req_o), 32'h1);
      checkOutput("cont_second_addr", mem_addr_o, 32'h104);

      // Duplicate fetch pulse while 0x104 is in flight is dropped
      applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
      tick(1);
      idleInputs();
      checkOutput("dup_addr_held", mem_addr_o, 32'h104);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h33334444);
      tick(1);
      idleInputs();
      checkOutput("dup_if_ready", 32'(if_ready_o), 32'h1);
      checkOutput("dup_if_rdata", if_rdata_o, 32'h33334444);
      tick(2);
      checkOutput("dup_no_reissue", 32'(mem_req_o), 32'h0);
      checkOutput("dup_no_second_ready", 32'(if_ready_o), 32'h0);

      // Read and write together give one write access only
      $display("[TB] read+write");
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'h12345678, 4'hF, 1'b0, 32'h0);
      tick(1);
      idleInputs();
      checkOutput("rw_we", 32'(mem_we_o), 32'h1);
      checkOutput("rw_wstrb", 32'(mem_wstrb_o), 32'hF);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h99);
      tick(1);
      idleInputs();
      checkOutput("rw_ready", 32'(d_ready_o), 32'h1);
      checkOutput("rw_rdata", d_rdata_o, 32'h0);
      tick(1);
      checkOutput("rw_single_access", 32'(mem_req_o), 32'h0);

      // Data load arriving during a fetch access is queued and served next
      $display("[TB] capture during access");
      applyStimulus(1'b1, 32'h600, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
      tick(1);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h700, 32'h0, 4'h0, 1'b0, 32'h0);
      tick(1);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'hAAAA5555);
      tick(1);
      idleInputs();
      checkOutput("cap_if_ready", 32'(if_ready_o), 32'h1);
      checkOutput("cap_if_rdata", if_rdata_o, 32'hAAAA5555);
      tick(1);
      checkOutput("cap_d_req", 32'(mem_req_o), 32'h1);
      checkOutput("cap_d_addr", mem_addr_o, 32'h700);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h5A5A0001);
      tick(1);
      idleInputs();
      checkOutput("cap_d_ready", 32'(d_ready_o), 32'h1);
      checkOutput("cap_d_rdata", d_rdata_o, 32'h5A5A0001);
      tick(1);

      // Reset during ACCESS abandons the request and discards its response
      $display("[TB] reset mid-access");
      applyStimulus(1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
      tick(1);
      idleInputs();
      checkOutput("mid_req_up", 32'(mem_req_o), 32'h1);
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      checkOutput("mid_req_drop", 32'(mem_req_o), 32'h0);
      checkOutput("mid_busy_drop", 32'(busy_o), 32'h0);
      checkOutput("mid_if_rdata_clr", if_rdata_o, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'hBAD0BAD0);
      tick(1);
      idleInputs();
      checkOutput("mid_no_if_ready", 32'(if_ready_o), 32'h0);
      checkOutput("mid_no_d_ready", 32'(d_ready_o), 32'h0);
      checkOutput("mid_slots_empty", 32'(mem_req_o), 32'h0);
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
      tick(1);
      idleInputs();
      checkOutput("mid_refetch_addr", mem_addr_o, 32'h100);
      tick(2);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h00500093);
      tick(1);
      idleInputs();
      checkOutput("mid_refetch_ready", 32'(if_ready_o), 32'h1);
      checkOutput("mid_refetch_rdata", if_rdata_o, 32'h00500093);
      tick(1);

      // Memory that never answers: watchdog abort, or an indefinite wait without it
      $display("[TB] stalled memory");
      applyStimulus(1'b1, 32'h800, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
      tick(1);
      idleInputs();
      checkOutput("stall_req_up", 32'(mem_req_o), 32'h1);
      tick(7);
      checkOutput("stall_req_at7", 32'(mem_req_o), 32'h1);
      tick(1);
`ifdef MEM_ARB_TIMEOUT_EN
      checkOutput("to_req_drop", 32'(mem_req_o), 32'h0);
      checkOutput("to_if_ready", 32'(if_ready_o), 32'h1);
      checkOutput("to_if_rdata", if_rdata_o, 32'h0);
      checkOutput("to_err", 32'(timeout_err_o), 32'h1);
      tick(3);
      checkOutput("to_err_sticky", 32'(timeout_err_o), 32'h1);
      checkOutput("to_busy", 32'(busy_o), 32'h0);
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      checkOutput("to_err_clr", 32'(timeout_err_o), 32'h0);
`else
      checkOutput("nto_req_held", 32'(mem_req_o), 32'h1);
      checkOutput("nto_no_ready", 32'(if_ready_o), 32'h0);
      tick(70);
      checkOutput("nto_req_held_long", 32'(mem_req_o), 32'h1);
      checkOutput("nto_busy_long", 32'(busy_o), 32'h1);
      checkOutput("nto_err_zero", 32'(timeout_err_o), 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0BADF00D);
      tick(1);
      idleInputs();
      checkOutput("nto_ready", 32'(if_ready_o), 32'h1);
      checkOutput("nto_rdata", if_rdata_o, 32'h0BADF00D);
`endif
      tick(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported memory between the instruction-fetch port and the data port of the multi-cycle core.
- Captures single-cycle request pulses from each requester and arbitrates them, data port first.
- Sequences each access on a hold-until-ready memory handshake and returns one registered response pulse per access.
- Sits between the core and the unified memory model/BRAM wrapper.

Parameters:
ADDR_WIDTH, 32, byte address width of all ports
DATA_WIDTH, 32, data width; wstrb is DATA_WIDTH/8
TIMEOUT_CYCLES, 64, watchdog limit in cycles (used only with MEM_ARB_TIMEOUT_EN); must be >=2

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset
if_req_i  input  1  instruction fetch request pulse
if_addr_i  input  ADDR_WIDTH  fetch address, sampled with if_req_i
if_rdata_o  output  DATA_WIDTH  fetched instruction, valid with if_ready_o
if_ready_o  output  1  one-cycle fetch completion pulse
d_read_i  input  1  data load request pulse
d_write_i  input  1  data store request pulse
d_addr_i  input  ADDR_WIDTH  data address, sampled with d_read_i or d_write_i
d_wdata_i  input  DATA_WIDTH  store data, sampled with d_write_i
d_wstrb_i  input  DATA_WIDTH/8  store byte strobes, sampled with d_write_i
d_rdata_o  output  DATA_WIDTH  load data, valid with d_ready_o; 0 for stores
d_ready_o  output  1  one-cycle data completion pulse
mem_req_o  output  1  memory request, held until accepted
mem_we_o  output  1  1 = write access
mem_addr_o  output  ADDR_WIDTH  memory address
mem_wdata_o  output  DATA_WIDTH  memory write data
mem_wstrb_o  output  DATA_WIDTH/8  memory byte strobes; 0 on reads
mem_rdata_i  input  DATA_WIDTH  memory read data, valid with mem_ready_i
mem_ready_i  input  1  memory completion
busy_o  output  1  high while in ACCESS state
timeout_err_o  output  1  sticky watchdog error

Behaviour:
- Reset (rst_n low at a clock edge):
  - State goes to IDLE; both pending slots clear.
  - All outputs are 0.
  - An in-flight mem_req_o drops on the next edge and its response is discarded; the memory side must tolerate an abandoned request.
- Pending slots:
  - There is one slot per requester: instruction {addr} and data {we, addr, wdata, wstrb}.
  - A request pulse loads its slot at the edge, unless that requester already has a pending or in-flight access. In that case the pulse is ignored and the first access is kept.
  - d_read_i and d_write_i high together: the write is taken and the read is ignored.
- States:
  - IDLE: the selection set is the pending slots plus pulses arriving this cycle. Data has fixed priority over instruction. If the set is non-empty, the winner is registered onto mem_* with mem_req_o=1 at the next edge, the state goes to ACCESS, and the winner's slot is consumed. The losing slot stays pending.
  - ACCESS: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o and mem_wstrb_o are held stable. On an edge where mem_ready_i=1:
    - mem_req_o drops.
    - The owner's *_ready_o pulses high for exactly the next cycle; if_rdata_o or d_rdata_o takes mem_rdata_i on reads and 0 on writes.
    - The state returns to IDLE.
- Latency:
  - Request pulse at edge N gives mem_req_o high from N+1.
  - mem_ready_i high in the cycle after edge N+1+k gives the ready pulse after edge N+2+k.
  - Minimum pulse-to-ready is 2 cycles.
  - Back-to-back accesses leave at least one IDLE cycle between them.
- Outputs:
  - *_rdata_o hold their last value between pulses.
  - The non-owner's ready output stays 0.
  - mem_wstrb_o is 0 and mem_we_o is 0 on reads.
- Requests arriving during ACCESS are captured into their slot if it is free.
- busy_o = (state == ACCESS).

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to ACCESS and increments each ACCESS cycle without mem_ready_i.
  - When the counter reaches TIMEOUT_CYCLES, the access aborts: mem_req_o drops and the owner gets its ready pulse with rdata = 0.
  - timeout_err_o is set and stays set until reset; the state returns to IDLE.
- Undefined: no counter; timeout_err_o is tied 0; an access waits indefinitely.

Test Plan:
- Fetch: if_req_i pulse with if_addr_i=0x100; memory returns 0x00500093 with mem_ready_i two cycles after mem_req_o rises -> mem_addr_o=0x100, mem_we_o=0; if_ready_o single pulse with if_rdata_o=0x00500093, 4 cycles after the request pulse.
- Store: d_write_i with addr 0x2004, wdata 0xCAFEF00D, wstrb 4'b0011; mem_ready_i in the first ACCESS cycle -> mem_we_o=1, mem_wstrb_o=0011, d_ready_o pulse 2 cycles after the request, d_rdata_o=0.
- Contention: if_req_i (0x104) and d_read_i (0x3000) in the same cycle -> 0x3000 is serviced first and d_ready_o pulses; after one IDLE cycle, 0x104 is issued and if_ready_o pulses.
- Duplicate and overlap: a second if_req_i (0x200) while 0x104 is in flight -> ignored; exactly one if_ready_o, for 0x104. d_read_i and d_write_i together -> a single write access.
- Reset mid-access: rst_n low for one edge during ACCESS -> mem_req_o=0 and busy_o=0 after that edge, no ready pulse, slots empty; a fresh fetch afterwards behaves as in the Fetch scenario.
- MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, mem_ready_i held 0 -> mem_req_o drops after 8 ACCESS cycles, if_ready_o pulses with 0, timeout_err_o stays 1 until rst_n.
